// File: rtl/acq_pkg.sv
// acq_pkg: shared state encoding, header layout and defaults for the acquisition event reader
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        NEXT_CHAN = 3'd2,
        WAIT_CHAN = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int         DEF_TIMEOUT_CYCLES = 40000;
    localparam logic [7:0] DEF_HDR_MARKER     = 8'hAC;

    localparam int HDR_MARKER_LSB = 56;
    localparam int HDR_TYPE_LSB   = 48;
    localparam int HDR_NUM_LSB    = 24;
    localparam int HDR_CHAN_LSB   = 16;
    localparam int HDR_CNT_LSB    = 0;

    function automatic logic [63:0] make_header(input logic [7:0] marker, input logic [4:0] typ,
                                                input logic [23:0] num, input logic [4:0] chan,
                                                input logic [15:0] cnt);
        logic [63:0] h;
        h = '0;
        h[HDR_MARKER_LSB +: 8] = marker;
        h[HDR_TYPE_LSB   +: 5] = typ;
        h[HDR_NUM_LSB    +: 24] = num;
        h[HDR_CHAN_LSB   +: 5] = chan;
        h[HDR_CNT_LSB    +: 16] = cnt;
        return h;
    endfunction

    function automatic logic [4:0] lowest_bit(input logic [4:0] m);
        return m & (~m + 5'd1);
    endfunction

endpackage

// File: rtl/chan_timeout_counter.sv
// chan_timeout_counter: counts cycles spent waiting on one channel and flags when the limit is reached
module chan_timeout_counter #(
    parameter int LIMIT = 40000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    assign expired = cnt == W'(LIMIT - 1);

    // Restart from zero on load, then count run cycles and hold once the limit is reached
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (run && !expired)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/acq_event_reader.sv
// acq_event_reader: pops one trigger word per event, sends its header, then reads out each enabled channel
module acq_event_reader
    import acq_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0] HDR_MARKER     = DEF_HDR_MARKER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  chan_en,
    input  logic        clear_errors,
    input  logic        fifo_valid,
    input  logic [31:0] fifo_data,
    output logic        fifo_ready,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [63:0] hdr_data,
    output logic [4:0]  chan_rd_req,
    input  logic [4:0]  chan_rd_done,
    output logic        readout_done,
    output logic [4:0]  timeout_err,
    output logic        seq_err,
    output logic        format_err,
    output logic [2:0]  state
);
    state_t      st;
    logic [4:0]  pending;
    logic [23:0] prev_num;
    logic        armed;
    logic [15:0] evt_cnt;
    logic        expired;
    logic        chan_hit;

    assign state    = st;
    assign chan_hit = |(chan_rd_done & chan_rd_req);

    chan_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .load   (st == NEXT_CHAN),
        .run    (st == WAIT_CHAN),
        .expired(expired)
    );

    // Event sequencer: pop, header handshake, per-channel readout, done pulse; sticky errors ride along
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            fifo_ready   <= 1'b0;
            hdr_valid    <= 1'b0;
            hdr_data     <= '0;
            chan_rd_req  <= '0;
            readout_done <= 1'b0;
            timeout_err  <= '0;
            seq_err      <= 1'b0;
            format_err   <= 1'b0;
            evt_cnt      <= '0;
            pending      <= '0;
            prev_num     <= '0;
            armed        <= 1'b0;
        end else begin
            if (clear_errors) begin
                timeout_err <= '0;
                seq_err     <= 1'b0;
                format_err  <= 1'b0;
            end
            case (st)
                IDLE:
                    if (fifo_valid && fifo_ready) begin
                        fifo_ready <= 1'b0;
                        hdr_valid  <= 1'b1;
                        hdr_data   <= make_header(HDR_MARKER, fifo_data[28:24], fifo_data[23:0], chan_en, evt_cnt);
                        pending    <= chan_en;
                        prev_num   <= fifo_data[23:0];
                        armed      <= 1'b1;
                        if (armed && fifo_data[23:0] != prev_num + 24'd1)
                            seq_err <= 1'b1;
                        if (|fifo_data[31:29])
                            format_err <= 1'b1;
                        st <= SEND_HDR;
                    end else
                        fifo_ready <= 1'b1;
                SEND_HDR:
                    if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        evt_cnt   <= evt_cnt + 16'd1;
                        st        <= NEXT_CHAN;
                    end
                NEXT_CHAN:
                    if (|pending) begin
                        chan_rd_req <= lowest_bit(pending);
                        st          <= WAIT_CHAN;
                    end else begin
                        readout_done <= 1'b1;
                        st           <= DONE;
                    end
                WAIT_CHAN:
                    if (chan_hit || expired) begin
                        if (!chan_hit)
                            timeout_err <= (clear_errors ? 5'd0 : timeout_err) | chan_rd_req;
                        pending     <= pending & ~chan_rd_req;
                        chan_rd_req <= '0;
                        st          <= NEXT_CHAN;
                    end
                DONE: begin
                    readout_done <= 1'b0;
                    fifo_ready   <= 1'b1;
                    st           <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acq_event_reader.sv
// tb_acq_event_reader: directed scenarios for the acquisition event reader
module tb_acq_event_reader;
    import acq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  chan_en = '0;
    logic        clear_errors = 1'b0;
    logic        fifo_valid = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_ready;
    logic        hdr_valid;
    logic        hdr_ready = 1'b0;
    logic [63:0] hdr_data;
    logic [4:0]  chan_rd_req;
    logic [4:0]  chan_rd_done = '0;
    logic        readout_done;
    logic [4:0]  timeout_err;
    logic        seq_err;
    logic        format_err;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    int         resp_delay = 3;
    logic [4:0] resp_mask = 5'h1f;
    logic [4:0] noise = '0;
    int         rcnt = 0;

    logic [4:0] req_log[$];
    logic [4:0] last_req = '0;
    int         req_high = 0;
    int         done_cnt = 0;

    acq_event_reader #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .chan_en     (chan_en),
        .clear_errors(clear_errors),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_ready  (fifo_ready),
        .hdr_valid   (hdr_valid),
        .hdr_ready   (hdr_ready),
        .hdr_data    (hdr_data),
        .chan_rd_req (chan_rd_req),
        .chan_rd_done(chan_rd_done),
        .readout_done(readout_done),
        .timeout_err (timeout_err),
        .seq_err     (seq_err),
        .format_err  (format_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Channel model: answers the active request after resp_delay cycles, plus optional noise on other bits
    initial forever begin
        @(negedge clk);
        if (chan_rd_req != 0) begin
            rcnt++;
            chan_rd_done = ((rcnt >= resp_delay) ? (chan_rd_req & resp_mask) : 5'd0) | noise;
        end else begin
            rcnt = 0;
            chan_rd_done = noise;
        end
    end

    // Monitor: log request order, cycles with a request held, and readout_done pulses
    initial forever begin
        @(negedge clk);
        if (chan_rd_req != 0 && chan_rd_req != last_req) req_log.push_back(chan_rd_req);
        last_req = chan_rd_req;
        if (chan_rd_req != 0) req_high++;
        if (readout_done) done_cnt++;
    end

    task automatic clear_logs();
        req_log.delete();
        req_high = 0;
        done_cnt = 0;
    endtask

    task automatic pop_word(input logic [31:0] w, input logic [4:0] en, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        fifo_data = w;
        chan_en = en;
        fifo_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (fifo_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        fifo_valid = 1'b0;
        chan_en = 5'h1f;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (readout_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 3'd0 || fifo_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: state=%0d fifo_ready=%b want 0 0", state, fifo_ready);
        end
        tests++;
        if (hdr_valid !== 1'b0 || hdr_data !== 64'h0 || chan_rd_req !== 5'd0 || readout_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: hv=%b hd=%h req=%b rd=%b want all zero", hdr_valid, hdr_data, chan_rd_req, readout_done);
        end
        tests++;
        if ({timeout_err, seq_err, format_err} !== 7'd0) begin
            fails++;
            $display("FAIL reset_errors: got %b want 0", {timeout_err, seq_err, format_err});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (fifo_ready !== 1'b1 || state !== IDLE) begin
            fails++;
            $display("FAIL reset_release: fifo_ready=%b state=%0d want 1 0", fifo_ready, state);
        end
    endtask

    task automatic test_basic();
        bit ok;
        hdr_ready = 1'b0;
        clear_logs();
        pop_word(32'h05000010, 5'b00101, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_pop: fifo_ready never high"); end
        tests++;
        if (hdr_valid !== 1'b1 || hdr_data !== 64'hAC05000010050000 || fifo_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_hdr: hv=%b hd=%h fr=%b want 1 ac05000010050000 0", hdr_valid, hdr_data, fifo_ready);
        end
        hdr_ready = 1'b1;
        wait_done(200, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (!ok || done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done: seen=%b pulses=%0d want 1 1", ok, done_cnt);
        end
        tests++;
        if (req_log.size() != 2 || req_log[0] !== 5'b00001 || req_log[1] !== 5'b00100 || req_high != 6) begin
            fails++;
            $display("FAIL basic_reqs: count=%0d high_cycles=%0d want 2 requests (ch0, ch2) 6 cycles", req_log.size(), req_high);
        end
    endtask

    task automatic test_hdr_stall();
        bit ok;
        bit stable;
        hdr_ready = 1'b0;
        clear_logs();
        pop_word(32'h02000011, 5'b00001, ok);
        stable = ok;
        for (int i = 0; i < 10; i++) begin
            if (hdr_valid !== 1'b1 || hdr_data !== 64'hAC02000011010001 || chan_rd_req !== 5'd0 || fifo_ready !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL stall_hold: hv=%b hd=%h req=%b want 1 ac02000011010001 00000", hdr_valid, hdr_data, chan_rd_req);
        end
        hdr_ready = 1'b1;
        wait_done(200, ok);
        tests++;
        if (!ok || req_log.size() != 1 || req_log[0] !== 5'b00001) begin
            fails++;
            $display("FAIL stall_readout: done=%b requests=%0d want 1 1", ok, req_log.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        hdr_ready = 1'b1;
        resp_mask = 5'd0;
        noise = 5'b11101;
        clear_logs();
        pop_word(32'h00000012, 5'b00010, ok);
        wait_done(100, ok);
        noise = 5'd0;
        resp_mask = 5'h1f;
        repeat (2) @(negedge clk);
        tests++;
        if (timeout_err !== 5'b00010) begin
            fails++;
            $display("FAIL timeout_flag: got %b want 00010", timeout_err);
        end
        tests++;
        if (req_high != 16 || req_log.size() != 1 || req_log[0] !== 5'b00010) begin
            fails++;
            $display("FAIL timeout_len: cycles=%0d requests=%0d want 16 1", req_high, req_log.size());
        end
        tests++;
        if (!ok || done_cnt != 1) begin
            fails++;
            $display("FAIL timeout_done: seen=%b pulses=%0d want 1 1", ok, done_cnt);
        end
    endtask

    task automatic test_seq();
        bit ok;
        hdr_ready = 1'b1;
        pop_word(32'h00FFFFFF, 5'd0, ok);
        wait_done(50, ok);
        @(negedge clk) clear_errors = 1'b1;
        @(negedge clk) clear_errors = 1'b0;
        tests++;
        if ({timeout_err, seq_err, format_err} !== 7'd0) begin
            fails++;
            $display("FAIL clear_all: got %b want 0", {timeout_err, seq_err, format_err});
        end
        pop_word(32'h00000000, 5'd0, ok);
        wait_done(50, ok);
        tests++;
        if (seq_err !== 1'b0) begin fails++; $display("FAIL seq_wrap: got %b want 0", seq_err); end
        pop_word(32'h00000005, 5'd0, ok);
        wait_done(50, ok);
        tests++;
        if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_gap: got %b want 1", seq_err); end
        @(negedge clk) clear_errors = 1'b1;
        @(negedge clk) clear_errors = 1'b0;
        tests++;
        if (seq_err !== 1'b0) begin fails++; $display("FAIL seq_clear: got %b want 0", seq_err); end
        clear_errors = 1'b1;
        pop_word(32'h00000007, 5'd0, ok);
        clear_errors = 1'b0;
        tests++;
        if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_set_wins: got %b want 1", seq_err); end
        wait_done(50, ok);
        @(negedge clk) clear_errors = 1'b1;
        @(negedge clk) clear_errors = 1'b0;
    endtask

    task automatic test_format();
        bit ok;
        hdr_ready = 1'b0;
        clear_logs();
        pop_word(32'hE1000001, 5'd0, ok);
        tests++;
        if (format_err !== 1'b1) begin fails++; $display("FAIL format_flag: got %b want 1", format_err); end
        tests++;
        if (hdr_valid !== 1'b1 || hdr_data !== 64'hAC01000001000007) begin
            fails++;
            $display("FAIL format_hdr: hv=%b hd=%h want 1 ac01000001000007", hdr_valid, hdr_data);
        end
        hdr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (readout_done !== 1'b0 || state !== NEXT_CHAN) begin
            fails++;
            $display("FAIL format_t1: rd=%b state=%0d want 0 2", readout_done, state);
        end
        @(negedge clk);
        tests++;
        if (readout_done !== 1'b1 || state !== DONE) begin
            fails++;
            $display("FAIL format_t2: rd=%b state=%0d want 1 4", readout_done, state);
        end
        @(negedge clk);
        tests++;
        if (readout_done !== 1'b0 || state !== IDLE || done_cnt != 1 || req_log.size() != 0) begin
            fails++;
            $display("FAIL format_end: rd=%b state=%0d pulses=%0d requests=%0d want 0 0 1 0", readout_done, state, done_cnt, req_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        hdr_ready = 1'b1;
        resp_mask = 5'd0;
        clear_logs();
        pop_word(32'h00000008, 5'b00001, ok);
        for (int i = 0; i < 20; i++) begin
            if (chan_rd_req != 0) break;
            @(negedge clk);
        end
        tests++;
        if (chan_rd_req !== 5'b00001) begin fails++; $display("FAIL midrst_req: got %b want 00001", chan_rd_req); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (chan_rd_req !== 5'd0 || state !== IDLE) begin
            fails++;
            $display("FAIL midrst_async: req=%b state=%0d want 00000 0", chan_rd_req, state);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (done_cnt != 0) begin fails++; $display("FAIL midrst_nodone: pulses=%0d want 0", done_cnt); end
        resp_mask = 5'h1f;
        clear_logs();
        hdr_ready = 1'b0;
        pop_word(32'h00000020, 5'b00100, ok);
        tests++;
        if (!ok || hdr_data !== 64'hAC00000020040000) begin
            fails++;
            $display("FAIL midrst_hdr: popped=%b hd=%h want 1 ac00000020040000", ok, hdr_data);
        end
        hdr_ready = 1'b1;
        wait_done(200, ok);
        tests++;
        if (!ok || req_log.size() != 1 || req_log[0] !== 5'b00100 || {timeout_err, seq_err, format_err} !== 7'd0) begin
            fails++;
            $display("FAIL midrst_next: done=%b requests=%0d errs=%b want 1 1 0", ok, req_log.size(), {timeout_err, seq_err, format_err});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hdr_stall();
        test_timeout();
        test_seq();
        test_format();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
